// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending-machine transaction controller.
// Optional change return is enabled by defining VEND_CHANGE_EN.
package vend_pkg;

  typedef enum logic [1:0] {IDLE, SELECTED, DISPENSE, CHANGE} state_t;

  localparam int MAX_PROD = 16;
  localparam int IDX_W    = 4;

  function automatic logic is_onehot(input logic [MAX_PROD-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_PROD-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PROD; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vend_hold_timer.sv
// Load/count-down timer shared by the dispense and change hold phases;
// done is high during the last cycle of a hold.
module vend_hold_timer #(
  parameter int HOLD_CYCLES = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int TW = $clog2(HOLD_CYCLES + 1);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = TW'(HOLD_CYCLES);
    end else if (count_q != '0) begin
      count_d = count_q - TW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign done = (count_q == TW'(1));

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: selection latch, credit accumulation,
// timed dispense and (with VEND_CHANGE_EN) timed change return.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int                          NPROD       = 4,
  parameter int                          CREDIT_W    = 4,
  parameter logic [NPROD*CREDIT_W-1:0]   PRICES      = {4'd10, 4'd7, 4'd5, 4'd3},
  parameter int                          HOLD_CYCLES = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NPROD-1:0]    sel,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  input  logic                cancel,
  output logic [NPROD-1:0]    prod_out,
  output logic [CREDIT_W-1:0] change_out,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  state_t               state_q, state_d;
  logic [NPROD-1:0]     sel_q, sel_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [NPROD-1:0]     prod_out_q, prod_out_d;
  logic                 busy_q, busy_d;
  logic [CREDIT_W-1:0]  change_q, change_d;
  logic [CREDIT_W-1:0]  change_out_q, change_out_d;

  logic [MAX_PROD-1:0]  sel_ext;
  logic [CREDIT_W-1:0]  price;
  logic [CREDIT_W:0]    sum;
  logic [CREDIT_W-1:0]  coin_credit;
  logic [CREDIT_W-1:0]  updated;
  logic                 timer_load;
  logic                 timer_done;

  assign sel_ext = MAX_PROD'(sel);

  always_comb begin
    price = '0;
    for (int i = 0; i < NPROD; i++) begin
      if (idx_q == IDX_W'(i)) price = PRICES[i*CREDIT_W +: CREDIT_W];
    end
  end

  vend_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (timer_load),
    .done  (timer_done)
  );

  // Coin is added (saturating) before both the payment and the cancel checks.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    credit_d   = credit_q;
    change_d   = change_q;
    timer_load = 1'b0;

    sum         = {1'b0, credit_q} + {1'b0, coin_value};
    coin_credit = sum[CREDIT_W] ? '1 : sum[CREDIT_W-1:0];
    updated     = coin_valid ? coin_credit : credit_q;

    case (state_q)
      IDLE: begin
        if (is_onehot(sel_ext)) begin
          sel_d   = sel;
          idx_d   = onehot_to_idx(sel_ext);
          state_d = SELECTED;
        end
      end
      SELECTED: begin
        if (coin_valid && (updated >= price)) begin
          state_d    = DISPENSE;
          timer_load = 1'b1;
`ifdef VEND_CHANGE_EN
          change_d   = updated - price;
          credit_d   = '0;
`else
          credit_d   = updated - price;
`endif
        end else if (cancel) begin
          credit_d = '0;
          state_d  = IDLE;
`ifdef VEND_CHANGE_EN
          if (updated != '0) begin
            change_d   = updated;
            state_d    = CHANGE;
            timer_load = 1'b1;
          end
`endif
        end else begin
          credit_d = updated;
        end
      end
      DISPENSE: begin
        if (timer_done) begin
          state_d = IDLE;
`ifdef VEND_CHANGE_EN
          if (change_q != '0) begin
            state_d    = CHANGE;
            timer_load = 1'b1;
          end
`endif
        end
      end
      CHANGE: begin
        if (timer_done) begin
          state_d  = IDLE;
          change_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    prod_out_d   = (state_d == DISPENSE) ? sel_d : '0;
    change_out_d = (state_d == CHANGE) ? change_d : '0;
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      idx_q      <= '0;
      credit_q   <= '0;
      prod_out_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      idx_q      <= idx_d;
      credit_q   <= credit_d;
      prod_out_q <= prod_out_d;
      busy_q     <= busy_d;
    end
  end

`ifdef VEND_CHANGE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      change_q     <= '0;
      change_out_q <= '0;
    end else begin
      change_q     <= change_d;
      change_out_q <= change_out_d;
    end
  end

  assign change_out = change_out_q;
`else
  assign change_q     = '0;
  assign change_out_q = change_out_d;
  assign change_out   = '0;
`endif

  assign prod_out = prod_out_q;
  assign credit   = credit_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed scenarios plus random traffic,
// compared each cycle against a transaction-level schedule model.
module tb_vend_ctrl;

  localparam int HOLD = 8;
`ifdef VEND_CHANGE_EN
  localparam bit CHG_EN = 1'b1;
`else
  localparam bit CHG_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sel = '0;
  logic       coinValid = 1'b0;
  logic [3:0] coinValue = '0;
  logic       cancel = 1'b0;
  logic [3:0] prodOut;
  logic [3:0] changeOut;
  logic [3:0] credit;
  logic       busy;

  int checks = 0;
  int failures = 0;

  vend_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .sel        (sel),
    .coin_valid (coinValid),
    .coin_value (coinValue),
    .cancel     (cancel),
    .prod_out   (prodOut),
    .change_out (changeOut),
    .credit     (credit),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Model: a queue of scheduled output cycles; the DUT is busy while a
  // product is selected or anything remains scheduled.
  typedef struct {
    int prod;
    int chg;
  } slot_t;

  slot_t sched[$];
  int    priceTab[4] = '{3, 5, 7, 10};
  bit    mSelected;
  int    mIdx;
  int    mCredit;

  task automatic modelReset();
    sched.delete();
    mSelected = 1'b0;
    mIdx = 0;
    mCredit = 0;
  endtask

  task automatic scheduleHold(input int prod, input int chg);
    slot_t s;
    s.prod = prod;
    s.chg = chg;
    for (int i = 0; i < HOLD; i++) sched.push_back(s);
  endtask

  task automatic modelStep(input logic [3:0] s, input bit cv, input int v, input bit can);
    int upd;
    if (sched.size() != 0) begin
      void'(sched.pop_front());
    end else if (!mSelected) begin
      if ($countones(s) == 1) begin
        mSelected = 1'b1;
        for (int i = 0; i < 4; i++) if (s[i]) mIdx = i;
      end
    end else begin
      upd = cv ? mCredit + v : mCredit;
      if (upd > 15) upd = 15;
      if (cv && upd >= priceTab[mIdx]) begin
        scheduleHold(1 << mIdx, 0);
        mSelected = 1'b0;
        if (CHG_EN) begin
          if (upd - priceTab[mIdx] > 0) scheduleHold(0, upd - priceTab[mIdx]);
          mCredit = 0;
        end else begin
          mCredit = upd - priceTab[mIdx];
        end
      end else if (can) begin
        if (CHG_EN && upd > 0) scheduleHold(0, upd);
        mSelected = 1'b0;
        mCredit = 0;
      end else begin
        mCredit = upd;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [3:0] expProd, expChg, expCredit;
    logic       expBusy;
    expProd   = (sched.size() != 0) ? 4'(sched[0].prod) : 4'd0;
    expChg    = (sched.size() != 0) ? 4'(sched[0].chg) : 4'd0;
    expCredit = 4'(mCredit);
    expBusy   = mSelected || (sched.size() != 0);
    checks++;
    assert (prodOut === expProd) else begin
      failures++;
      $error("[TB] FAIL %s prod_out observed=%b expected=%b", tag, prodOut, expProd);
    end
    checks++;
    assert (changeOut === expChg) else begin
      failures++;
      $error("[TB] FAIL %s change_out observed=%0d expected=%0d", tag, changeOut, expChg);
    end
    checks++;
    assert (credit === expCredit) else begin
      failures++;
      $error("[TB] FAIL %s credit observed=%0d expected=%0d", tag, credit, expCredit);
    end
    checks++;
    assert (busy === expBusy) else begin
      failures++;
      $error("[TB] FAIL %s busy observed=%b expected=%b", tag, busy, expBusy);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] s, input bit cv, input int v, input bit can,
                               input string tag);
    @(negedge clock);
    sel = s;
    coinValid = cv;
    coinValue = 4'(v);
    cancel = can;
    @(posedge clock);
    modelStep(s, cv, v, can);
    #1;
    checkOutput(tag);
  endtask

  task automatic idleCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(4'b0000, 1'b0, 0, 1'b0, tag);
  endtask

  initial begin
    logic [3:0] rs;
    modelReset();
    #12;
    checkOutput("reset_state");
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] sel 0010, coins 2 and 3");
    applyStimulus(4'b0010, 1'b0, 0, 1'b0, "sel_p1");
    applyStimulus(4'b0000, 1'b1, 2, 1'b0, "coin2");
    applyStimulus(4'b0000, 1'b1, 3, 1'b0, "coin3_pay");
    idleCycles(18, "dispense_p1");

    $display("[TB] sel 1000, coins 5 5 4");
    applyStimulus(4'b1000, 1'b0, 0, 1'b0, "sel_p3");
    applyStimulus(4'b0000, 1'b1, 5, 1'b0, "coin5a");
    applyStimulus(4'b0000, 1'b1, 5, 1'b0, "coin5b_pay");
    applyStimulus(4'b0000, 1'b1, 4, 1'b0, "coin4_ignored");
    idleCycles(18, "dispense_p3");

    $display("[TB] sel 0001, coin 7 with change");
    applyStimulus(4'b0001, 1'b0, 0, 1'b0, "sel_p0");
    applyStimulus(4'b0000, 1'b1, 7, 1'b0, "coin7_pay");
    idleCycles(20, "dispense_change");

    $display("[TB] sel 0100, coin 2 then cancel with coin 3");
    applyStimulus(4'b0100, 1'b0, 0, 1'b0, "sel_p2");
    applyStimulus(4'b0000, 1'b1, 2, 1'b0, "coin2_p2");
    applyStimulus(4'b0000, 1'b1, 3, 1'b1, "cancel_coin3");
    idleCycles(12, "refund");

    $display("[TB] non-one-hot sel, then saturating coins");
    applyStimulus(4'b0110, 1'b1, 3, 1'b1, "nonhot_sel");
    applyStimulus(4'b0000, 1'b0, 0, 1'b0, "nonhot_idle");
    applyStimulus(4'b0001, 1'b0, 0, 1'b0, "sel_p0b");
    applyStimulus(4'b0000, 1'b1, 9, 1'b0, "coin9a_pay");
    applyStimulus(4'b0000, 1'b1, 9, 1'b0, "coin9b_ignored");
    idleCycles(20, "dispense_sat");
    applyStimulus(4'b1000, 1'b0, 0, 1'b0, "sel_p3b");
    applyStimulus(4'b0000, 1'b1, 9, 1'b0, "coin9c");
    applyStimulus(4'b0000, 1'b1, 9, 1'b0, "coin9d_sat_pay");
    idleCycles(20, "dispense_sat2");

    $display("[TB] cancel with nothing paid");
    applyStimulus(4'b0100, 1'b0, 0, 1'b0, "sel_p2c");
    applyStimulus(4'b0000, 1'b0, 0, 1'b1, "cancel_empty");
    idleCycles(2, "after_cancel_empty");

    $display("[TB] reset mid-dispense");
    applyStimulus(4'b0010, 1'b0, 0, 1'b0, "sel_p1r");
    applyStimulus(4'b0000, 1'b1, 15, 1'b0, "coin15_pay");
    idleCycles(3, "dispense_pre_reset");
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("async_reset");
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(4'b0010, 1'b0, 0, 1'b0, "sel_post_reset");
    applyStimulus(4'b0000, 1'b1, 5, 1'b0, "coin5_post_reset");
    idleCycles(10, "dispense_post_reset");

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       rs = 4'b0000;
        1, 3:    rs = 4'(1 << $urandom_range(0, 3));
        default: rs = 4'($urandom_range(0, 15));
      endcase
      applyStimulus(rs, ($urandom_range(0, 9) < 3), int'($urandom_range(0, 15)),
                    ($urandom_range(0, 19) == 0), "random");
    end
    idleCycles(20, "drain");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
